iecdrv_track_head: RTL and testbench

Emulated read/write head for the drive's GCR track buffer. Walks the bit-addressed port of the track bit memory at the selected speed-zone bit rate. In read mode it assembles serial bits into bytes and detects SYNC; in write mode it serialises bytes from the drive VIA into the buffer. It sits between the drive's VIA port B/CA1 logic and the bit-wide port of the track memory.

---
 rtl/iecdrv_track_head.sv | 151 +++++++++++++++
 tb/tb_iecdrv_track_head.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/iecdrv_track_head.sv
// Emulated read/write head: walks the bit port of the GCR track buffer at the zone bit rate,
// assembling bytes and detecting SYNC in read mode and serialising VIA bytes in write mode.
module iecdrv_track_head #(
    parameter int ADDRWIDTH = 13
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   ce,
    input  logic                   mtr,
    input  logic                   mode,
    input  logic [1:0]             speed_zone,
    input  logic                   soe,
    input  logic [ADDRWIDTH+2:0]   track_len,
    input  logic [7:0]             din,
    output logic [7:0]             dout,
    output logic                   byte_ready,
    output logic                   sync_n,
    output logic [ADDRWIDTH+2:0]   mem_addr,
    input  logic                   mem_q,
    output logic                   mem_d,
    output logic                   mem_we
);

    localparam int AW = ADDRWIDTH + 3;

    logic [5:0]    cell_q, cell_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [2:0]    bitcnt_q, bitcnt_d;
    logic [8:0]    win_q, win_d;
    logic [7:0]    wsh_q, wsh_d;
    logic [7:0]    dout_q, dout_d;
    logic          br_q, br_d;
    logic          sync_q, sync_d;
    logic          memd_q, memd_d;
    logic          we_q, we_d;
    logic          mode_q;

    logic [5:0]    limit;
    logic          tick;
    logic          mode_chg;
    logic          adv;
    logic [9:0]    win_next;

    // Cell lengths of 64/60/56/52 ce give compare values 63/59/55/51.
    assign limit    = 6'd63 - {2'b00, speed_zone, 2'b00};
    assign tick     = ce & mtr & (cell_q == limit);
    assign mode_chg = (mode != mode_q);
    // A write holds the old address through its strobe clk, so it advances one clk later.
    assign adv      = (tick & (mode | mode_chg)) | we_q;
    // The stored nine bits plus the incoming bit form the 10-bit SYNC window.
    assign win_next = {win_q, mem_q};

    always_comb begin
        cell_d   = cell_q;
        addr_d   = addr_q;
        bitcnt_d = bitcnt_q;
        win_d    = win_q;
        wsh_d    = wsh_q;
        dout_d   = dout_q;
        br_d     = 1'b0;
        sync_d   = sync_q;
        memd_d   = memd_q;
        we_d     = 1'b0;

        if (ce && mtr) begin
            cell_d = tick ? 6'd0 : cell_q + 6'd1;
        end

        if (adv) begin
            if ((track_len == '0) || (addr_q >= track_len - AW'(1))) begin
                addr_d = '0;
            end else begin
                addr_d = addr_q + AW'(1);
            end
        end

        if (mode_chg) begin
            bitcnt_d = 3'd0;
            win_d    = '0;
            if (!mode) begin
                wsh_d = din;
            end
        end else if (tick && mode) begin
            win_d = win_next[8:0];
            if (&win_next) begin
                sync_d   = 1'b0;
                bitcnt_d = 3'd0;
            end else begin
                sync_d = 1'b1;
                if (bitcnt_q == 3'd7) begin
                    dout_d   = win_next[7:0];
                    br_d     = soe;
                    bitcnt_d = 3'd0;
                end else begin
                    bitcnt_d = bitcnt_q + 3'd1;
                end
            end
        end else if (tick && !mode) begin
            memd_d = wsh_q[7];
            we_d   = 1'b1;
            if (bitcnt_q == 3'd7) begin
                wsh_d    = din;
                br_d     = soe;
                bitcnt_d = 3'd0;
            end else begin
                wsh_d    = {wsh_q[6:0], 1'b0};
                bitcnt_d = bitcnt_q + 3'd1;
            end
        end

        if (!mode) begin
            sync_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cell_q   <= '0;
            addr_q   <= '0;
            bitcnt_q <= '0;
            win_q    <= '0;
            wsh_q    <= '0;
            dout_q   <= '0;
            br_q     <= 1'b0;
            sync_q   <= 1'b1;
            memd_q   <= 1'b0;
            we_q     <= 1'b0;
            mode_q   <= mode;
        end else begin
            cell_q   <= cell_d;
            addr_q   <= addr_d;
            bitcnt_q <= bitcnt_d;
            win_q    <= win_d;
            wsh_q    <= wsh_d;
            dout_q   <= dout_d;
            br_q     <= br_d;
            sync_q   <= sync_d;
            memd_q   <= memd_d;
            we_q     <= we_d;
            mode_q   <= mode;
        end
    end

    assign dout       = dout_q;
    assign byte_ready = br_q;
    assign sync_n     = sync_q;
    assign mem_addr   = addr_q;
    assign mem_d      = memd_q;
    assign mem_we     = we_q;

endmodule

// File: tb/tb_iecdrv_track_head.sv
// Directed bench for iecdrv_track_head with a 2-clk-latency bit memory model and write log.
module tb_iecdrv_track_head;

    localparam int AW = 16;

    logic          clk = 1'b0;
    logic          reset, ce, mtr, mode, soe;
    logic [1:0]    speed_zone;
    logic [AW-1:0] track_len;
    logic [7:0]    din;
    logic [7:0]    dout;
    logic          byte_ready, sync_n;
    logic [AW-1:0] mem_addr;
    logic          mem_q = 1'b0;
    logic          mem_d, mem_we;

    logic          membits [0:255];
    logic          q1 = 1'b0;
    int            br_cnt = 0;
    int            wr_n = 0;
    logic [AW-1:0] wr_addr [0:31];
    logic          wr_data [0:31];

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    iecdrv_track_head #(.ADDRWIDTH(13)) dut (
        .clk(clk), .reset(reset), .ce(ce), .mtr(mtr), .mode(mode),
        .speed_zone(speed_zone), .soe(soe), .track_len(track_len), .din(din),
        .dout(dout), .byte_ready(byte_ready), .sync_n(sync_n),
        .mem_addr(mem_addr), .mem_q(mem_q), .mem_d(mem_d), .mem_we(mem_we)
    );

    // Bit memory read port with two clocks of latency; writes are captured in a log.
    always @(posedge clk) begin
        q1    <= membits[mem_addr[7:0]];
        mem_q <= q1;
        if (byte_ready) br_cnt <= br_cnt + 1;
        if (mem_we && wr_n < 32) begin
            wr_addr[wr_n] <= mem_addr;
            wr_data[wr_n] <= mem_d;
            wr_n          <= wr_n + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_addr(output int n);
        logic [AW-1:0] prev;
        prev = mem_addr;
        n = 0;
        do begin
            step();
            n++;
        end while (mem_addr == prev && n < 300);
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    initial begin
        int n;
        int br0;
        logic [15:0] exp_w;

        for (int i = 0; i < 256; i++) membits[i] = 1'b0;
        for (int i = 0; i < 10; i++) membits[i] = 1'b1;
        membits[11] = 1'b1;
        membits[13] = 1'b1;
        membits[16] = 1'b1;

        reset = 1'b1; ce = 1'b1; mtr = 1'b0; mode = 1'b1; soe = 1'b1;
        speed_zone = 2'd3; track_len = 16'd64; din = 8'h00;
        repeat (3) step();
        chk("rst_addr", mem_addr, 0);
        chk("rst_dout", dout, 8'h00);
        chk("rst_br", byte_ready, 0);
        chk("rst_sync", sync_n, 1);
        chk("rst_we", mem_we, 0);
        chk("rst_d", mem_d, 0);

        // Read: eight ones give byte 0xFF, ten ones give SYNC, then 0x52.
        reset = 1'b0; mtr = 1'b1;
        for (int k = 0; k < 18; k++) begin
            wait_addr(n);
            chk("cell_z3", n, 52);
            chk("addr_inc", mem_addr, k + 1);
            if (k == 7) begin
                chk("br_ff", byte_ready, 1);
                chk("dout_ff", dout, 8'hFF);
            end
            if (k == 9) chk("sync_low", sync_n, 0);
            if (k == 10) chk("sync_high", sync_n, 1);
            if (k == 17) begin
                chk("br_52", byte_ready, 1);
                chk("dout_52", dout, 8'h52);
            end
        end
        chk("br_cnt_read", br_cnt, 1);
        speed_zone = 2'd0;
        step();
        chk("br_one_clk", byte_ready, 0);
        chk("br_cnt_read2", br_cnt, 2);
        wait_addr(n);
        chk("cell_z0a", n, 63);
        chk("addr_19", mem_addr, 19);
        wait_addr(n);
        chk("cell_z0b", n, 64);
        chk("addr_20", mem_addr, 20);

        // Write 0x55 then the reloaded 0x0F.
        mode = 1'b0; din = 8'h55; speed_zone = 2'd3;
        step();
        din = 8'h0F;
        br0 = br_cnt;
        n = 0;
        while (wr_n < 16 && n < 2000) begin
            step();
            n++;
        end
        chk("wr_count", wr_n, 16);
        exp_w = 16'b0101_0101_0000_1111;
        for (int i = 0; i < 16; i++) begin
            chk("wr_addr", wr_addr[i], 20 + i);
            chk("wr_data", wr_data[i], exp_w[15 - i]);
        end
        chk("wr_br", br_cnt - br0, 2);
        chk("wr_sync", sync_n, 1);

        // Wrap at track_len, shrink below the head, zero length.
        mode = 1'b1; track_len = 16'd16;
        pulse_reset();
        repeat (14) wait_addr(n);
        chk("wrap_14", mem_addr, 14);
        wait_addr(n);
        chk("wrap_15", mem_addr, 15);
        wait_addr(n);
        chk("wrap_0", mem_addr, 0);
        wait_addr(n);
        chk("wrap_1", mem_addr, 1);
        track_len = 16'd64;
        repeat (9) wait_addr(n);
        chk("shrink_at", mem_addr, 10);
        track_len = 16'd4;
        wait_addr(n);
        chk("shrink_0", mem_addr, 0);
        track_len = 16'd64;
        wait_addr(n);
        chk("len0_pre", mem_addr, 1);
        track_len = 16'd0;
        wait_addr(n);
        chk("len0_a", mem_addr, 0);
        repeat (100) step();
        chk("len0_b", mem_addr, 0);

        // Motor stop after 3 bits of a byte.
        track_len = 16'd64;
        pulse_reset();
        br0 = br_cnt;
        repeat (3) wait_addr(n);
        chk("mtr_addr3", mem_addr, 3);
        repeat (20) step();
        mtr = 1'b0;
        repeat (500) step();
        chk("mtr_hold_addr", mem_addr, 3);
        chk("mtr_hold_br", br_cnt - br0, 0);
        chk("mtr_br_low", byte_ready, 0);
        mtr = 1'b1;
        wait_addr(n);
        chk("mtr_resume_cell", n, 32);
        chk("mtr_addr4", mem_addr, 4);
        repeat (3) wait_addr(n);
        chk("mtr_no_early_br", br_cnt - br0, 0);
        wait_addr(n);
        chk("mtr_addr8", mem_addr, 8);
        chk("mtr_br", byte_ready, 1);
        chk("mtr_dout", dout, 8'hFF);

        // Reset mid-byte.
        pulse_reset();
        chk("mid_rst_dout", dout, 8'h00);
        chk("mid_rst_addr", mem_addr, 0);
        chk("mid_rst_br", byte_ready, 0);
        chk("mid_rst_sync", sync_n, 1);
        chk("mid_rst_we", mem_we, 0);
        repeat (4) wait_addr(n);
        chk("mid_addr4", mem_addr, 4);
        pulse_reset();
        chk("mid_rst2_addr", mem_addr, 0);
        br0 = br_cnt;
        repeat (4) wait_addr(n);
        chk("mid_no_partial", byte_ready, 0);
        chk("mid_no_partial_cnt", br_cnt - br0, 0);
        repeat (4) wait_addr(n);
        chk("mid_addr8", mem_addr, 8);
        chk("mid_br", byte_ready, 1);
        chk("mid_dout", dout, 8'hFF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
